// File: rtl/cipher_pkg.sv
// Shared types and constants for the stream-cipher control blocks.
package cipher_pkg;

    typedef enum logic [1:0] {
        IF_IDLE,
        IF_ARMED,
        IF_RUN,
        IF_DRAIN
    } if_state_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WARMUP,
        STREAM,
        FINISH
    } seq_state_t;

    localparam int DEFAULT_WARMUP_ROUNDS = 16;

endpackage

// File: rtl/cipher_down_counter.sv
// Loadable down counter that saturates at zero and flags the values 1 and 0.
module cipher_down_counter
    import cipher_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         is_one,
    output logic         is_zero
);

    logic [W-1:0] count;

    // Load wins over decrement; decrement is ignored once the count is zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign is_one  = (count == W'(1));
    assign is_zero = (count == '0);

endmodule

// File: rtl/keystream_sequencer.sv
// Per-message sequencing of the keystream core: optional key load, warm-up, then byte streaming.
module keystream_sequencer
    import cipher_pkg::*;
#(
    parameter int WARMUP_ROUNDS = DEFAULT_WARMUP_ROUNDS,
    parameter int LEN_W         = 8,
    parameter int WCNT_W        = $clog2(WARMUP_ROUNDS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             rekey,
    input  logic             sink_ready,
    output logic             core_load,
    output logic             core_step,
    output logic             ks_valid,
    output logic             msg_done,
    output logic             busy
);

    seq_state_t state, state_next;
    logic       key_pending;
    logic       warm_load, warm_dec, warm_one, warm_zero;
    logic       rem_load, rem_dec, rem_one, rem_zero;

    cipher_down_counter #(.W(WCNT_W)) u_warm_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (warm_load),
        .value   (WCNT_W'(WARMUP_ROUNDS)),
        .dec     (warm_dec),
        .is_one  (warm_one),
        .is_zero (warm_zero)
    );

    cipher_down_counter #(.W(LEN_W)) u_rem_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (rem_load),
        .value   (msg_len),
        .dec     (rem_dec),
        .is_one  (rem_one),
        .is_zero (rem_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A rekey arriving on the LOAD cycle itself must survive for the next message.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_pending <= 1'b1;
        end else if (rekey) begin
            key_pending <= 1'b1;
        end else if (state == LOAD) begin
            key_pending <= 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        core_load  = 1'b0;
        core_step  = 1'b0;
        ks_valid   = 1'b0;
        msg_done   = 1'b0;
        warm_load  = 1'b0;
        warm_dec   = 1'b0;
        rem_load   = 1'b0;
        rem_dec    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    rem_load = 1'b1;
                    if (key_pending) begin
                        state_next = LOAD;
                    end else if (msg_len == '0) begin
                        state_next = FINISH;
                    end else begin
                        state_next = STREAM;
                    end
                end
            end
            LOAD: begin
                core_load  = 1'b1;
                warm_load  = 1'b1;
                state_next = WARMUP;
            end
            WARMUP: begin
                core_step = 1'b1;
                warm_dec  = 1'b1;
                if (warm_one || warm_zero) begin
                    state_next = rem_zero ? FINISH : STREAM;
                end
            end
            STREAM: begin
                // Zero remaining is unreachable here; treat it as done rather than stepping.
                core_step = sink_ready && !rem_zero;
                ks_valid  = sink_ready && !rem_zero;
                rem_dec   = sink_ready;
                if (rem_zero || (rem_one && sink_ready)) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                msg_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_keystream_sequencer.sv
// Scoreboard bench for keystream_sequencer: expected output vectors are queued as stimulus is driven.
module tb_keystream_sequencer;

    localparam int WR = 16;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] msg_len;
    logic       rekey;
    logic       sink_ready;
    logic       core_load;
    logic       core_step;
    logic       ks_valid;
    logic       msg_done;
    logic       busy;

    logic [4:0] exp_q[$];
    logic [4:0] mon_e;
    logic [4:0] outs;
    int         total;
    int         bad;
    bit         pending;

    keystream_sequencer #(.WARMUP_ROUNDS(WR), .LEN_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .msg_len    (msg_len),
        .rekey      (rekey),
        .sink_ready (sink_ready),
        .core_load  (core_load),
        .core_step  (core_step),
        .ks_valid   (ks_valid),
        .msg_done   (msg_done),
        .busy       (busy)
    );

    assign outs = {core_load, core_step, ks_valid, msg_done, busy};

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    // One cycle of stimulus plus the outputs expected during that cycle.
    task automatic drive_cycle(input logic s, input logic rk, input logic rdy,
                               input logic [7:0] ml, input logic [4:0] e);
        @(posedge clk);
        #1;
        start      = s;
        rekey      = rk;
        sink_ready = rdy;
        msg_len    = ml;
        exp_q.push_back(e);
    endtask

    // rekey_at: -1 none, 0 on the LOAD cycle, k>0 on the k-th streaming cycle.
    task automatic run_msg(input int len, input int rekey_at, input bit rnd, input logic [31:0] pat);
        bit   cold;
        int   got;
        int   k;
        logic r;
        logic rk;
        cold = pending;
        got  = 0;
        k    = 0;
        drive_cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 8'(len), 5'b00000);
        if (cold) begin
            drive_cycle(1'b0, rekey_at == 0, 1'b1, 8'($urandom_range(0, 255)), 5'b10001);
            pending = (rekey_at == 0);
            for (int i = 0; i < WR; i++) begin
                drive_cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 5'b01001);
            end
        end
        while (got < len && k < 200) begin
            r  = rnd ? 1'($urandom_range(0, 1)) : pat[k % 32];
            rk = (rekey_at == k + 1);
            drive_cycle(1'b0, rk, r, 8'($urandom_range(0, 255)), {1'b0, r, r, 1'b0, 1'b1});
            if (rk) pending = 1'b1;
            if (r) got++;
            k++;
        end
        if (k >= 200) check("stream_budget", got, len);
        drive_cycle(1'b0, 1'b0, 1'b1, 8'd0, 5'b00011);
        drive_cycle(1'b0, 1'b0, 1'b0, 8'd0, 5'b00000);
    endtask

    // scoreboard
    always @(negedge clk) begin
        if (!rst && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("out_vec", 32'(outs), 32'(mon_e));
        end
    end

    initial begin
        total      = 0;
        bad        = 0;
        pending    = 1'b1;
        rst        = 1'b1;
        start      = 1'b0;
        rekey      = 1'b0;
        sink_ready = 1'b0;
        msg_len    = 8'd0;
        #3;
        check("reset_outs", 32'(outs), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        run_msg(3, -1, 1'b0, 32'hFFFF_FFFF);   // cold: load, 16 warm-up, 3 bytes
        run_msg(2, -1, 1'b0, 32'hFFFF_FFFF);   // warm
        run_msg(3, -1, 1'b0, 32'h0000_0019);   // ready 1,0,0,1,1
        run_msg(0, -1, 1'b0, 32'hFFFF_FFFF);   // warm zero length
        run_msg(4, 2, 1'b0, 32'hFFFF_FFFF);    // rekey mid-stream
        run_msg(0, 0, 1'b0, 32'hFFFF_FFFF);    // cold zero length, rekey on LOAD
        run_msg(2, -1, 1'b1, 32'h0);           // must reload again
        for (int i = 0; i < 4; i++) begin
            run_msg($urandom_range(1, 6), -1, 1'b1, 32'h0);
        end

        // reset during the fifth warm-up cycle
        drive_cycle(1'b0, 1'b1, 1'b0, 8'd0, 5'b00000);
        pending = 1'b1;
        drive_cycle(1'b1, 1'b0, 1'b1, 8'd5, 5'b00000);
        drive_cycle(1'b0, 1'b0, 1'b1, 8'd9, 5'b10001);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b1, 8'd9, 5'b01001);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", 32'(outs), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold", 32'(outs), 32'd0);
        end
        @(posedge clk);
        #1;
        rst     = 1'b0;
        pending = 1'b1;
        run_msg(2, -1, 1'b0, 32'hFFFF_FFFF);   // reload after reset

        repeat (2) @(posedge clk);
        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
